// File: rtl/alu_sched_pkg.sv
// +--------------------------------------------------------------------+
// | alu_sched_pkg : shared ALU op codes, FSM states and flag indices    |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
`default_nettype none

package alu_sched_pkg;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_AND = 2'd2;
  localparam logic [1:0] ALU_XOR = 2'd3;

  localparam int ZF = 2;
  localparam int SF = 1;
  localparam int OF = 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/alu_sched_alu_core.sv
// +--------------------------------------------------------------------+
// | alu_core : combinational W-bit add/sub/and/xor with {ZF,SF,OF}      |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
`default_nettype none

module alu_core
  import alu_sched_pkg::*;
#(
  parameter int W = 64
) (
  input  logic [1:0]   ifun,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] result,
  output logic [2:0]   flags
);

  logic [W-1:0] w_sum;
  logic [W-1:0] w_diff;
  logic         w_of;

  assign w_sum  = a + b;
  assign w_diff = a - b;

  always_comb begin
    result = w_sum;
    w_of   = 1'b0;
    case (ifun)
      ALU_ADD: begin
        result = w_sum;
        w_of   = (a[W-1] == b[W-1]) && (w_sum[W-1] != a[W-1]);
      end
      ALU_SUB: begin
        result = w_diff;
        w_of   = (a[W-1] != b[W-1]) && (w_diff[W-1] != a[W-1]);
      end
      ALU_AND: result = a & b;
      default: result = a ^ b;
    endcase
  end

  always_comb begin
    flags     = 3'b000;
    flags[ZF] = (result == '0);
    flags[SF] = result[W-1];
    flags[OF] = w_of;
  end

endmodule

`default_nettype wire

// File: rtl/alu_sched.sv
// +--------------------------------------------------------------------+
// | alu_sched : round-robin sequencer for the shared ALU, owns cc reg.  |
// | Define ALU_SCHED_FASTRSP_EN for the 1-cycle (no EXEC) variant.      |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
`default_nettype none

module alu_sched
  import alu_sched_pkg::*;
#(
  parameter int         W      = 64,
  parameter logic [2:0] CC_RST = 3'b100
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [1:0]   req0_ifun,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req0_setcc,
  input  logic [1:0]   req1_ifun,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic         req1_setcc,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_result,
  output logic [2:0]   rsp_flags,
  output logic [2:0]   cc
);

  state_t       r_state;
  state_t       w_next;
  logic         r_rr_ptr;
  logic         r_setcc;
  logic         w_gnt_valid;
  logic         w_gnt_id;
  logic         w_accept;
  logic [1:0]   w_sel_ifun;
  logic [W-1:0] w_sel_a;
  logic [W-1:0] w_sel_b;
  logic         w_sel_setcc;
  logic [1:0]   w_alu_ifun;
  logic [W-1:0] w_alu_a;
  logic [W-1:0] w_alu_b;
  logic [W-1:0] w_alu_result;
  logic [2:0]   w_alu_flags;
  logic         w_rsp_load;
  logic         w_load_id;

  // Contention goes to rr_ptr; a lone requester always wins.
  always_comb begin
    w_gnt_valid = |req_valid;
    case (req_valid)
      2'b10:   w_gnt_id = 1'b1;
      2'b11:   w_gnt_id = r_rr_ptr;
      default: w_gnt_id = 1'b0;
    endcase
  end

  assign w_accept    = (r_state == S_IDLE) && w_gnt_valid;
  assign req_ready   = w_accept ? (w_gnt_id ? 2'b10 : 2'b01) : 2'b00;
  assign w_sel_ifun  = w_gnt_id ? req1_ifun  : req0_ifun;
  assign w_sel_a     = w_gnt_id ? req1_a     : req0_a;
  assign w_sel_b     = w_gnt_id ? req1_b     : req0_b;
  assign w_sel_setcc = w_gnt_id ? req1_setcc : req0_setcc;

`ifdef ALU_SCHED_FASTRSP_EN
  localparam state_t c_after_accept = S_RESP;

  // Live request fields feed the ALU; the accept edge captures the result.
  assign w_alu_ifun = w_sel_ifun;
  assign w_alu_a    = w_sel_a;
  assign w_alu_b    = w_sel_b;
  assign w_rsp_load = w_accept;
  assign w_load_id  = w_gnt_id;
`else
  localparam state_t c_after_accept = S_EXEC;

  logic [1:0]   r_ifun;
  logic [W-1:0] r_a;
  logic [W-1:0] r_b;
  logic         r_id;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ifun <= ALU_ADD;
      r_a    <= '0;
      r_b    <= '0;
      r_id   <= 1'b0;
    end else if (w_accept) begin
      r_ifun <= w_sel_ifun;
      r_a    <= w_sel_a;
      r_b    <= w_sel_b;
      r_id   <= w_gnt_id;
    end
  end

  assign w_alu_ifun = r_ifun;
  assign w_alu_a    = r_a;
  assign w_alu_b    = r_b;
  assign w_rsp_load = (r_state == S_EXEC);
  assign w_load_id  = r_id;
`endif

  alu_core #(.W(W)) u_alu_core (
    .ifun   (w_alu_ifun),
    .a      (w_alu_a),
    .b      (w_alu_b),
    .result (w_alu_result),
    .flags  (w_alu_flags)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = c_after_accept;
      S_EXEC:  w_next = S_RESP;
      S_RESP:  if (rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr   <= 1'b0;
      r_setcc    <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_flags  <= 3'b000;
      cc         <= CC_RST;
    end else begin
      if (w_accept) begin
        r_rr_ptr <= ~w_gnt_id;
        r_setcc  <= w_sel_setcc;
      end
      if (w_rsp_load) begin
        rsp_valid  <= 1'b1;
        rsp_id     <= w_load_id;
        rsp_result <= w_alu_result;
        rsp_flags  <= w_alu_flags;
      end else if ((r_state == S_RESP) && rsp_ready) begin
        rsp_valid <= 1'b0;
        if (r_setcc) cc <= rsp_flags;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_sched.sv
// +--------------------------------------------------------------------+
// | tb_alu_sched : directed + randomized self-checking bench            |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_alu_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req0_ifun, req1_ifun;
  logic [63:0] req0_a, req0_b, req1_a, req1_b;
  logic        req0_setcc, req1_setcc;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [63:0] rsp_result;
  logic [2:0]  rsp_flags, cc;

  always #5 clk = ~clk;

`ifdef ALU_SCHED_FASTRSP_EN
  localparam int c_lat = 1;
`else
  localparam int c_lat = 2;
`endif
  localparam logic [63:0] c_max = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] c_min = 64'h8000_0000_0000_0000;
  localparam logic [63:0] c_all = 64'hFFFF_FFFF_FFFF_FFFF;

  alu_sched dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req0_ifun(req0_ifun), .req0_a(req0_a), .req0_b(req0_b), .req0_setcc(req0_setcc),
    .req1_ifun(req1_ifun), .req1_a(req1_a), .req1_b(req1_b), .req1_setcc(req1_setcc),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .cc(cc)
  );

  int       tests = 0;
  int       fails = 0;
  logic [2:0] m_cc;
  logic       m_rr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: signed 65-bit arithmetic, overflow = true value out of 64-bit range.
  function automatic logic [66:0] ref_alu(input logic [1:0] f, input logic [63:0] a,
                                          input logic [63:0] b);
    logic signed [64:0] wide;
    logic [63:0] r;
    logic        of;
    wide = '0;
    case (f)
      2'd0:    wide = $signed({a[63], a}) + $signed({b[63], b});
      2'd1:    wide = $signed({a[63], a}) - $signed({b[63], b});
      default: wide = '0;
    endcase
    case (f)
      2'd0, 2'd1: begin r = wide[63:0]; of = (wide > 65'sd9223372036854775807) ||
                                             (wide < -65'sd9223372036854775808); end
      2'd2:       begin r = a & b; of = 1'b0; end
      default:    begin r = a ^ b; of = 1'b0; end
    endcase
    return {(r == 64'd0), r[63], of, r};
  endfunction

  task automatic set_req(input logic id, input logic [1:0] f, input logic [63:0] a,
                         input logic [63:0] b, input logic sc);
    if (id) begin req1_ifun = f; req1_a = a; req1_b = b; req1_setcc = sc; end
    else    begin req0_ifun = f; req0_a = a; req0_b = b; req0_setcc = sc; end
  endtask

  // Waits (bounded) for rsp_valid after an accept edge; checks latency and payload.
  task automatic wait_rsp(input logic id, input logic [66:0] e);
    int lat;
    lat = 1;
    while (!rsp_valid && lat < 6) begin @(posedge clk); #1; lat++; end
    chk("latency", 64'(lat), 64'(c_lat));
    chk("rsp_id", {63'd0, rsp_id}, {63'd0, id});
    chk("rsp_result", rsp_result, e[63:0]);
    chk("rsp_flags", {61'd0, rsp_flags}, {61'd0, e[66:64]});
    chk("cc_before_hs", {61'd0, cc}, {61'd0, m_cc});
  endtask

  task automatic rsp_handshake(input logic sc, input logic [2:0] fl);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    if (sc) m_cc = fl;
    chk("rsp_valid_drop", {63'd0, rsp_valid}, 64'd0);
    chk("cc_after_hs", {61'd0, cc}, {61'd0, m_cc});
  endtask

  task automatic run_op(input logic id, input logic [1:0] f, input logic [63:0] a,
                        input logic [63:0] b, input logic sc, input int hold);
    logic [66:0] e;
    logic [63:0] h_res;
    logic [2:0]  h_fl;
    e = ref_alu(f, a, b);
    set_req(id, f, a, b, sc);
    req_valid = id ? 2'b10 : 2'b01;
    #1;
    chk("req_ready_grant", {62'd0, req_ready}, id ? 64'd2 : 64'd1);
    @(posedge clk); #1;
    req_valid = 2'b00;
    m_rr = ~id;
    chk("req_ready_busy", {62'd0, req_ready}, 64'd0);
    wait_rsp(id, e);
    h_res = rsp_result; h_fl = rsp_flags;
    for (int i = 0; i < hold; i++) begin
      req_valid = 2'b11;
      @(posedge clk); #1;
      chk("hold_valid", {63'd0, rsp_valid}, 64'd1);
      chk("hold_result", rsp_result, h_res);
      chk("hold_flags", {61'd0, rsp_flags}, {61'd0, h_fl});
      chk("hold_ready", {62'd0, req_ready}, 64'd0);
      chk("hold_cc", {61'd0, cc}, {61'd0, m_cc});
    end
    req_valid = 2'b00;
    rsp_handshake(sc, e[66:64]);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    m_cc = 3'b100; m_rr = 1'b0;
    chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("rst_rsp_result", rsp_result, 64'd0);
    chk("rst_rsp_flags_id", {60'd0, rsp_flags, rsp_id}, 64'd0);
    chk("rst_cc", {61'd0, cc}, 64'd4);
    chk("rst_req_ready", {62'd0, req_ready}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [66:0] e;
    logic [63:0] ra, rb;
    logic        g, sc;
    logic [1:0]  f;
    rst = 1'b0; req_valid = 2'b00; rsp_ready = 1'b0;
    set_req(1'b0, 2'd0, 64'd0, 64'd0, 1'b0);
    set_req(1'b1, 2'd0, 64'd0, 64'd0, 1'b0);
    m_cc = 3'b100; m_rr = 1'b0;

    // Asynchronous reset asserted mid-cycle
    @(posedge clk); #3;
    do_reset();

    run_op(1'b0, 2'd1, 64'd5, 64'd5, 1'b1, 0);
    run_op(1'b0, 2'd0, c_max, 64'd1, 1'b1, 0);
    run_op(1'b0, 2'd1, c_min, 64'd1, 1'b0, 0);
    run_op(1'b1, 2'd3, 64'hF0, 64'hF0, 1'b0, 0);
    chk("cc_isolated", {61'd0, cc}, 64'd3);
    run_op(1'b0, 2'd2, c_all, c_all, 1'b1, 0);
    chk("cc_and", {61'd0, cc}, 64'd2);

    // Back-pressure with the other requester knocking
    run_op(1'b1, 2'd0, 64'd100, 64'd23, 1'b1, 5);

    // Round-robin with both requesters continuously valid
    set_req(1'b0, 2'($urandom_range(3)), {$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
    set_req(1'b1, 2'($urandom_range(3)), {$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
    req_valid = 2'b11;
    for (int k = 0; k < 6; k++) begin
      #1;
      g = m_rr;
      chk("rr_grant", {62'd0, req_ready}, g ? 64'd2 : 64'd1);
      e = g ? ref_alu(req1_ifun, req1_a, req1_b) : ref_alu(req0_ifun, req0_a, req0_b);
      @(posedge clk); #1;
      m_rr = ~g;
      set_req(g, 2'($urandom_range(3)), {$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
      wait_rsp(g, e);
      rsp_handshake(1'b0, 3'b000);
    end
    req_valid = 2'b00;

    // Lone requester 1 right after a requester-1 grant
    run_op(1'b1, 2'd0, 64'd1, 64'd2, 1'b0, 0);
    run_op(1'b1, 2'd1, 64'd1, 64'd2, 1'b1, 0);

    // Reset right after accept, then again while the response is pending
    for (int k = 0; k < 2; k++) begin
      set_req(1'b0, 2'd0, c_max, 64'd1, 1'b1);
      req_valid = 2'b01;
      @(posedge clk); #1;
      req_valid = 2'b00;
      if (k == 1) begin
        for (int j = 1; j < c_lat; j++) begin @(posedge clk); #1; end
        chk("pre_rst_valid", {63'd0, rsp_valid}, 64'd1);
      end
      #2;
      do_reset();
      chk("post_rst_idle_valid", {63'd0, rsp_valid}, 64'd0);
      run_op(1'b1, 2'd3, 64'hA5, 64'h5A, 1'b1, 1);
    end

    // Randomized traffic against the reference model
    for (int k = 0; k < 24; k++) begin
      case ($urandom_range(4))
        0: ra = c_max; 1: ra = c_min; 2: ra = 64'd0; default: ra = {$urandom, $urandom};
      endcase
      case ($urandom_range(4))
        0: rb = 64'd1; 1: rb = c_all; 2: rb = ra; default: rb = {$urandom, $urandom};
      endcase
      g  = 1'($urandom_range(1));
      f  = 2'($urandom_range(3));
      sc = 1'($urandom_range(1));
      run_op(g, f, ra, rb, sc, int'($urandom_range(2)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
